// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: binary hh:mm:ss + dd/mm/yy (2000-2099) clock/calendar
// with debounced mode/inc/dec keys and an optional hh:mm alarm compare.
module rtc_calendar_core #(
    parameter int TICK_DIV     = 32768,
    parameter int DEBOUNCE_DIV = 328,
    parameter int DEBOUNCE_LEN = 4,
    parameter int ALARM_EN     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       alarm_arm,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic [2:0] status,
    output logic       running,
    output logic       sec_pulse,
    output logic       alarm_hit
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int HL = DEBOUNCE_LEN / 2;
    localparam logic [DEBOUNCE_LEN-1:0] PRESS_PAT = {{HL{1'b1}}, {HL{1'b0}}};

    typedef enum logic [2:0] {
        S_RUN, S_HOUR, S_MIN, S_YEAR, S_MONTH, S_DAY, S_AHOUR, S_AMIN
    } state_t;

    function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [6:0] y);
        unique case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up) return (v == hi) ? lo : v + 7'd1;
        else    return (v == lo) ? hi : v - 7'd1;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic [2:0][DEBOUNCE_LEN-1:0] key_q;
    state_t state_q, state_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, amin_q, amin_d;
    logic [4:0] hour_q, hour_d, day_q, day_d, ahour_q, ahour_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic edited_q, edited_d, sec_pulse_q, sec_pulse_d, hit_q, hit_d;

    logic [2:0] raw, ev;
    logic strobe, tick, ev_inc, ev_dec, edit;
    logic [4:0] dim_cur;
    state_t last_set;

    assign raw      = {key_dec_n, key_inc_n, key_mode_n};
    assign strobe   = (dbc_q == DW'(DEBOUNCE_DIV - 1));
    assign tick     = (presc_q == PW'(TICK_DIV - 1)) && (state_q == S_RUN);
    assign ev[0]    = strobe && (key_q[0] == PRESS_PAT);
    assign ev[1]    = strobe && (key_q[1] == PRESS_PAT);
    assign ev[2]    = strobe && (key_q[2] == PRESS_PAT);
    assign ev_inc   = ev[1] && !ev[0];
    assign ev_dec   = ev[2] && !ev[0];
    assign edit     = ev_inc ^ ev_dec;
    assign dim_cur  = dim_f(month_q, year_q);
    assign last_set = (ALARM_EN != 0) ? S_AMIN : S_DAY;

    always_comb begin
        presc_d     = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
        dbc_d       = strobe ? '0 : dbc_q + DW'(1);
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        ahour_d     = ahour_q;
        amin_d      = amin_q;
        edited_d    = edited_q;
        sec_pulse_d = tick;
        hit_d       = 1'b0;
        // Full carry chain resolves within one edge
        if (tick) begin
            sec_d = sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                min_d = min_q + 6'd1;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = hour_q + 5'd1;
                    if (hour_q == 5'd23) begin
                        hour_d = 5'd0;
                        day_d  = day_q + 5'd1;
                        if (day_q == dim_cur) begin
                            day_d   = 5'd1;
                            month_d = month_q + 4'd1;
                            if (month_q == 4'd12) begin
                                month_d = 4'd1;
                                year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                            end
                        end
                    end
                end
            end
            hit_d = (ALARM_EN != 0) && alarm_arm && (sec_d == 6'd0) &&
                    (min_d == amin_q) && (hour_d == ahour_q);
        end
        if (ev[0]) begin
            if (state_q == last_set) begin
                state_d = S_RUN;
                if (edited_q) begin
                    sec_d    = 6'd0;
                    presc_d  = '0;
                    edited_d = 1'b0;
                end
            end else begin
                state_d = state_t'(state_q + 3'd1);
            end
        end else if (edit) begin
            unique case (state_q)
                S_HOUR: begin
                    hour_d   = 5'(wrap_step(7'(hour_q), 7'd0, 7'd23, ev_inc));
                    edited_d = 1'b1;
                end
                S_MIN: begin
                    min_d    = 6'(wrap_step(7'(min_q), 7'd0, 7'd59, ev_inc));
                    edited_d = 1'b1;
                end
                S_YEAR: begin
                    year_d   = wrap_step(year_q, 7'd0, 7'd99, ev_inc);
                    edited_d = 1'b1;
                end
                S_MONTH: begin
                    month_d  = 4'(wrap_step(7'(month_q), 7'd1, 7'd12, ev_inc));
                    edited_d = 1'b1;
                end
                S_DAY: begin
                    day_d    = 5'(wrap_step(7'(day_q), 7'd1, 7'(dim_cur), ev_inc));
                    edited_d = 1'b1;
                end
                S_AHOUR: if (ALARM_EN != 0)
                    ahour_d = 5'(wrap_step(7'(ahour_q), 7'd0, 7'd23, ev_inc));
                S_AMIN: if (ALARM_EN != 0)
                    amin_d = 6'(wrap_step(7'(amin_q), 7'd0, 7'd59, ev_inc));
                default: ;
            endcase
        end
        // A month/year edit may leave day past the new month end
        if (day_q > dim_cur) day_d = dim_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            dbc_q       <= '0;
            key_q       <= '1;
            state_q     <= S_RUN;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 7'd0;
            ahour_q     <= 5'd0;
            amin_q      <= 6'd0;
            edited_q    <= 1'b0;
            sec_pulse_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            dbc_q       <= dbc_d;
            for (int i = 0; i < 3; i++)
                if (strobe) key_q[i] <= {key_q[i][DEBOUNCE_LEN-2:0], raw[i]};
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            ahour_q     <= ahour_d;
            amin_q      <= amin_d;
            edited_q    <= edited_d;
            sec_pulse_q <= sec_pulse_d;
            hit_q       <= hit_d;
        end
    end

    assign second       = sec_q;
    assign minute       = min_q;
    assign hour         = hour_q;
    assign day          = day_q;
    assign month        = month_q;
    assign year         = year_q;
    assign alarm_hour   = ahour_q;
    assign alarm_minute = amin_q;
    assign status       = state_q;
    assign running      = (state_q == S_RUN);
    assign sec_pulse    = sec_pulse_q;
    assign alarm_hit    = hit_q;
endmodule
